// File: rtl/ace_ccu_pkg.sv
// Shared types for the ACE CCU scheduler: channel/request/response structs,
// the scheduler state enum and a small index-width helper.
package ace_ccu_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [5:0] atop;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } ace_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } ace_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    AR_ADDR,
    R_DATA,
    AW_ADDR,
    W_DATA,
    B_RESP
  } ccu_sched_state_e;

  // Width of an index into n ports; never narrower than one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ace_ccu_sched_rr.sv
// Round-robin winner selection: scans the request vector starting at the
// pointer and returns the first requesting index, wrapping past the top.
module ace_ccu_sched_rr
  import ace_ccu_pkg::*;
#(
  parameter  int unsigned NoPorts = 2,
  localparam int unsigned IdxW    = idxWidth(NoPorts)
) (
  input  logic [NoPorts-1:0] i_req,
  input  logic [IdxW-1:0]    i_ptr,
  output logic [IdxW-1:0]    o_idx,
  output logic               o_valid
);

  localparam logic [IdxW:0] NumPortsW = (IdxW+1)'(NoPorts);

  logic [IdxW:0]   w_sum;
  logic [IdxW-1:0] w_cand;

  // First requester found when walking from the pointer upwards, modulo NoPorts.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < int'(NoPorts); i++) begin
      w_sum = {1'b0, i_ptr} + (IdxW+1)'(i);
      if (w_sum >= NumPortsW) begin
        w_sum = w_sum - NumPortsW;
      end
      w_cand = w_sum[IdxW-1:0];
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/ace_ccu_sched.sv
// ACE CCU scheduler: serializes shareable traffic from several requesters onto
// one CCU mux port, one transaction in flight, so IDs pass through unchanged.
// Optional build macro ACE_CCU_SCHED_PERF_EN adds a completed-transaction
// counter output txn_cnt_o.
module ace_ccu_sched
  import ace_ccu_pkg::*;
#(
  parameter int unsigned NoSlvPorts = 2,
  parameter type         req_t      = ace_req_t,
  parameter type         resp_t     = ace_resp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  req_t  [NoSlvPorts-1:0]  slv_reqs_i,
  output resp_t [NoSlvPorts-1:0]  slv_resps_o,
  output req_t                    mst_req_o,
  input  resp_t                   mst_resp_i,
  output logic                    busy_o
`ifdef ACE_CCU_SCHED_PERF_EN
  ,
  output logic [31:0]             txn_cnt_o
`endif
);

  localparam int unsigned IdxW = idxWidth(NoSlvPorts);

  ccu_sched_state_e  r_state, w_state_next;
  logic [IdxW-1:0]   r_winner, w_winner_next;
  logic [IdxW-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [IdxW-1:0]   w_ptr_inc;
  logic [IdxW-1:0]   w_rr_idx;
  logic              w_rr_valid;
  logic [NoSlvPorts-1:0] w_req_vec;
  logic              w_done;
  req_t              w_win_req;

  assign w_win_req = slv_reqs_i[r_winner];
  assign w_ptr_inc = (r_winner == IdxW'(NoSlvPorts - 1)) ? '0 : r_winner + 1'b1;
  assign busy_o    = (r_state != IDLE);

  // A port competes for the grant when it has either address channel valid.
  always_comb begin
    w_req_vec = '0;
    for (int i = 0; i < int'(NoSlvPorts); i++) begin
      w_req_vec[i] = slv_reqs_i[i].aw_valid | slv_reqs_i[i].ar_valid;
    end
  end

  ace_ccu_sched_rr #(
    .NoPorts (NoSlvPorts)
  ) u_rr (
    .i_req   (w_req_vec),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  // State, locked winner and round-robin pointer; reset abandons any transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_winner <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_winner <= w_winner_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  // Next state plus channel routing between the locked winner and the mst port.
  always_comb begin
    w_state_next  = r_state;
    w_winner_next = r_winner;
    w_rr_ptr_next = r_rr_ptr;
    w_done        = 1'b0;
    mst_req_o     = '0;
    slv_resps_o   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_rr_valid) begin
          w_winner_next = w_rr_idx;
          w_state_next  = slv_reqs_i[w_rr_idx].aw_valid ? AW_ADDR : AR_ADDR;
        end
      end
      AR_ADDR: begin
        mst_req_o.ar                     = w_win_req.ar;
        mst_req_o.ar_valid               = w_win_req.ar_valid;
        slv_resps_o[r_winner].ar_ready   = mst_resp_i.ar_ready;
        if (w_win_req.ar_valid && mst_resp_i.ar_ready) begin
          w_state_next = R_DATA;
        end
      end
      R_DATA: begin
        slv_resps_o[r_winner].r          = mst_resp_i.r;
        slv_resps_o[r_winner].r_valid    = mst_resp_i.r_valid;
        mst_req_o.r_ready                = w_win_req.r_ready;
        if (mst_resp_i.r_valid && w_win_req.r_ready && mst_resp_i.r.last) begin
          w_state_next  = IDLE;
          w_rr_ptr_next = w_ptr_inc;
          w_done        = 1'b1;
        end
      end
      AW_ADDR: begin
        mst_req_o.aw                     = w_win_req.aw;
        mst_req_o.aw_valid               = w_win_req.aw_valid;
        slv_resps_o[r_winner].aw_ready   = mst_resp_i.aw_ready;
        if (w_win_req.aw_valid && mst_resp_i.aw_ready) begin
          w_state_next = W_DATA;
        end
      end
      W_DATA: begin
        mst_req_o.w                      = w_win_req.w;
        mst_req_o.w_valid                = w_win_req.w_valid;
        slv_resps_o[r_winner].w_ready    = mst_resp_i.w_ready;
        if (w_win_req.w_valid && mst_resp_i.w_ready && w_win_req.w.last) begin
          w_state_next = B_RESP;
        end
      end
      B_RESP: begin
        slv_resps_o[r_winner].b          = mst_resp_i.b;
        slv_resps_o[r_winner].b_valid    = mst_resp_i.b_valid;
        mst_req_o.b_ready                = w_win_req.b_ready;
        if (mst_resp_i.b_valid && w_win_req.b_ready) begin
          w_state_next  = IDLE;
          w_rr_ptr_next = w_ptr_inc;
          w_done        = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef ACE_CCU_SCHED_PERF_EN
  logic [31:0] r_txn_cnt;

  // Completed-transaction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_txn_cnt <= '0;
    end else if (w_done) begin
      r_txn_cnt <= r_txn_cnt + 32'd1;
    end
  end

  assign txn_cnt_o = r_txn_cnt;
`endif

  // Atomic writes are not supported through this path.
  assert property (@(posedge clk_i) disable iff (rst_i)
    mst_req_o.aw_valid |-> (mst_req_o.aw.atop == '0));

endmodule

// File: tb/tb_ace_ccu_sched.sv
// Randomized bench for ace_ccu_sched: requesters and the mst port are driven
// cycle by cycle, while a transaction-level model decides which port must be
// served next (round robin, write before read) and what data must reach it.
module tb_ace_ccu_sched;
  import ace_ccu_pkg::*;

  localparam int N = 2;

  logic                  clk;
  logic                  rst;
  ace_req_t  [N-1:0]     slvReqs;
  ace_resp_t [N-1:0]     slvResps;
  ace_req_t              mstReq;
  ace_resp_t             mstResp;
  logic                  busy;
`ifdef ACE_CCU_SCHED_PERF_EN
  logic [31:0]           txnCnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  // Model state: next port to favour, pending work per port, completions.
  int       modelPtr  = 0;
  int       modelTxns = 0;
  bit       pendW [N];
  bit       pendR [N];
  aw_chan_t txnAw [N];
  ar_chan_t txnAr [N];

  ace_ccu_sched #(
    .NoSlvPorts (N)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .slv_reqs_i  (slvReqs),
    .slv_resps_o (slvResps),
    .mst_req_o   (mstReq),
    .mst_resp_i  (mstResp),
    .busy_o      (busy)
`ifdef ACE_CCU_SCHED_PERF_EN
    ,
    .txn_cnt_o   (txnCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every port other than the winner must see no ready and no response valid.
  task automatic checkQuiet(input int winner, input string tag);
    for (int q = 0; q < N; q++) begin
      if (q != winner) begin
        checkOutput(tag, {slvResps[q].aw_ready, slvResps[q].ar_ready, slvResps[q].w_ready,
                          slvResps[q].b_valid, slvResps[q].r_valid}, 0);
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doWrite(input int win);
    int stall = $urandom_range(0, 2);
    data_t data;
    mstResp.aw_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      checkOutput("awValidStall", mstReq.aw_valid, 1);
      checkOutput("awReadyStall", slvResps[win].aw_ready, 0);
      nextCycle();
    end
    mstResp.aw_ready = 1'b1;
    #1;
    checkOutput("awValid", mstReq.aw_valid, 1);
    checkOutput("awAddr", mstReq.aw.addr, txnAw[win].addr);
    checkOutput("awId", mstReq.aw.id, txnAw[win].id);
    checkOutput("awLen", mstReq.aw.len, txnAw[win].len);
    checkOutput("arDuringAw", mstReq.ar_valid, 0);
    checkOutput("awReady", slvResps[win].aw_ready, 1);
    checkQuiet(win, "quietAw");
    nextCycle();
    mstResp.aw_ready = 1'b0;
    slvReqs[win].aw_valid = 1'b0;
    for (int b = 0; b <= int'(txnAw[win].len); b++) begin
      data = $urandom;
      slvReqs[win].w.data = data;
      slvReqs[win].w.last = (b == int'(txnAw[win].len));
      slvReqs[win].w_valid = 1'b1;
      mstResp.w_ready = 1'b1;
      #1;
      checkOutput("wValid", mstReq.w_valid, 1);
      checkOutput("wData", mstReq.w.data, data);
      checkOutput("wLast", mstReq.w.last, (b == int'(txnAw[win].len)));
      checkOutput("wReady", slvResps[win].w_ready, 1);
      checkQuiet(win, "quietW");
      nextCycle();
    end
    slvReqs[win].w_valid = 1'b0;
    mstResp.w_ready = 1'b0;
    mstResp.b_valid = 1'b1;
    mstResp.b.id = txnAw[win].id;
    mstResp.b.resp = 2'($urandom);
    #1;
    checkOutput("bValid", slvResps[win].b_valid, 1);
    checkOutput("bId", slvResps[win].b.id, txnAw[win].id);
    checkOutput("bReadyMst", mstReq.b_ready, 1);
    checkQuiet(win, "quietB");
    nextCycle();
    mstResp.b_valid = 1'b0;
  endtask

  task automatic doRead(input int win);
    int stall = $urandom_range(0, 2);
    data_t data;
    mstResp.ar_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      checkOutput("arValidStall", mstReq.ar_valid, 1);
      checkOutput("arReadyStall", slvResps[win].ar_ready, 0);
      nextCycle();
    end
    mstResp.ar_ready = 1'b1;
    #1;
    checkOutput("arValid", mstReq.ar_valid, 1);
    checkOutput("arAddr", mstReq.ar.addr, txnAr[win].addr);
    checkOutput("arId", mstReq.ar.id, txnAr[win].id);
    checkOutput("awDuringAr", mstReq.aw_valid, 0);
    checkOutput("arReady", slvResps[win].ar_ready, 1);
    checkQuiet(win, "quietAr");
    nextCycle();
    mstResp.ar_ready = 1'b0;
    slvReqs[win].ar_valid = 1'b0;
    for (int b = 0; b <= int'(txnAr[win].len); b++) begin
      data = $urandom;
      mstResp.r_valid = 1'b1;
      mstResp.r.id = txnAr[win].id;
      mstResp.r.data = data;
      mstResp.r.resp = 2'b00;
      mstResp.r.last = (b == int'(txnAr[win].len));
      #1;
      checkOutput("rValid", slvResps[win].r_valid, 1);
      checkOutput("rData", slvResps[win].r.data, data);
      checkOutput("rId", slvResps[win].r.id, txnAr[win].id);
      checkOutput("rReadyMst", mstReq.r_ready, 1);
      checkOutput("busyR", busy, 1);
      checkQuiet(win, "quietR");
      nextCycle();
    end
    mstResp.r_valid = 1'b0;
  endtask

  // Present one set of requests (masks per port) and serve them all to completion.
  task automatic applyStimulus(input logic [N-1:0] wMask, input logic [N-1:0] rMask,
                               input bit sameId, input int fixedLen);
    int  win;
    bit  isW;
    bit  anyPend;
    for (int p = 0; p < N; p++) begin
      if (wMask[p]) begin
        txnAw[p].id   = sameId ? 4'h3 : 4'($urandom);
        txnAw[p].addr = {8'(p), 24'($urandom)};
        txnAw[p].len  = (fixedLen >= 0) ? 8'(fixedLen) : 8'($urandom_range(0, 3));
        txnAw[p].atop = '0;
        slvReqs[p].aw = txnAw[p];
        slvReqs[p].aw_valid = 1'b1;
        pendW[p] = 1'b1;
      end
      if (rMask[p]) begin
        txnAr[p].id   = sameId ? 4'h3 : 4'($urandom);
        txnAr[p].addr = {8'(p + 16), 24'($urandom)};
        txnAr[p].len  = (fixedLen >= 0) ? 8'(fixedLen) : 8'($urandom_range(0, 3));
        slvReqs[p].ar = txnAr[p];
        slvReqs[p].ar_valid = 1'b1;
        pendR[p] = 1'b1;
      end
    end
    anyPend = 1'b1;
    while (anyPend) begin
      win = -1;
      for (int i = 0; i < N; i++) begin
        int c = (modelPtr + i) % N;
        if (win < 0 && (pendW[c] || pendR[c])) win = c;
      end
      isW = pendW[win];
      checkOutput("idleBusy", busy, 0);
      checkOutput("idleAwValid", mstReq.aw_valid, 0);
      checkOutput("idleArValid", mstReq.ar_valid, 0);
      checkQuiet(-1, "idleQuiet");
      nextCycle();
      checkOutput("grantBusy", busy, 1);
      if (isW) begin
        doWrite(win);
        pendW[win] = 1'b0;
      end else begin
        doRead(win);
        pendR[win] = 1'b0;
      end
      modelPtr = (win + 1) % N;
      modelTxns++;
      anyPend = 1'b0;
      for (int i = 0; i < N; i++) anyPend |= pendW[i] | pendR[i];
    end
    checkOutput("endBusy", busy, 0);
  endtask

  // Reset lands while the second of four W beats is on the bus.
  task automatic resetMidWrite();
    slvReqs[0].aw = '{id: 4'h5, addr: 32'h0000_1000, len: 8'd3, atop: 6'd0};
    slvReqs[0].aw_valid = 1'b1;
    nextCycle();
    mstResp.aw_ready = 1'b1;
    nextCycle();
    mstResp.aw_ready = 1'b0;
    slvReqs[0].aw_valid = 1'b0;
    slvReqs[0].w = '{data: 32'hA0, last: 1'b0};
    slvReqs[0].w_valid = 1'b1;
    mstResp.w_ready = 1'b1;
    nextCycle();
    slvReqs[0].w.data = 32'hA1;
    #1;
    checkOutput("preRstWValid", mstReq.w_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstWValid", mstReq.w_valid, 0);
    checkOutput("rstWReady", slvResps[0].w_ready, 0);
`ifdef ACE_CCU_SCHED_PERF_EN
    checkOutput("rstTxnCnt", txnCnt, 0);
`endif
    slvReqs[0].w_valid = 1'b0;
    mstResp.w_ready = 1'b0;
    nextCycle();
    rst = 1'b0;
    modelPtr = 0;
    modelTxns = 0;
    nextCycle();
    nextCycle();
    checkOutput("postRstBusy", busy, 0);
    checkOutput("postRstWValid", mstReq.w_valid, 0);
    checkQuiet(-1, "postRstQuiet");
  endtask

  initial begin
    logic [N-1:0] wm;
    logic [N-1:0] rm;
    rst = 1'b1;
    slvReqs = '0;
    for (int p = 0; p < N; p++) begin
      slvReqs[p].b_ready = 1'b1;
      slvReqs[p].r_ready = 1'b1;
      pendW[p] = 1'b0;
      pendR[p] = 1'b0;
    end
    mstResp = '0;
    nextCycle();
    nextCycle();
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetMstValids", {mstReq.aw_valid, mstReq.ar_valid, mstReq.w_valid,
                                   mstReq.r_ready, mstReq.b_ready}, 0);
    checkQuiet(-1, "resetQuiet");
`ifdef ACE_CCU_SCHED_PERF_EN
    checkOutput("resetTxnCnt", txnCnt, 0);
`endif
    rst = 1'b0;
    nextCycle();

    $display("[TB] directed: two writes from pointer 0");
    applyStimulus(2'b11, 2'b00, 1'b0, 0);
    $display("[TB] directed: port0 read len 3");
    applyStimulus(2'b00, 2'b01, 1'b0, 3);
    $display("[TB] directed: port1 write and read together");
    applyStimulus(2'b10, 2'b10, 1'b0, -1);
    $display("[TB] directed: both ports read with ID 3");
    applyStimulus(2'b00, 2'b11, 1'b1, -1);

    $display("[TB] random rounds");
    for (int r = 0; r < 40; r++) begin
      wm = N'($urandom);
      rm = N'($urandom);
      if ((wm | rm) != '0) begin
        applyStimulus(wm, rm, 1'($urandom), -1);
      end
    end
`ifdef ACE_CCU_SCHED_PERF_EN
    checkOutput("txnCnt", txnCnt, 64'(modelTxns));
`endif

    $display("[TB] reset during write data");
    resetMidWrite();
    applyStimulus(2'b01, 2'b10, 1'b0, -1);
`ifdef ACE_CCU_SCHED_PERF_EN
    checkOutput("txnCntAfterRst", txnCnt, 64'(modelTxns));
    force dut.r_txn_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_txn_cnt;
    checkOutput("txnCntPreload", txnCnt, 64'h0000_0000_FFFF_FFFF);
    applyStimulus(2'b00, 2'b01, 1'b0, 0);
    checkOutput("txnCntWrap", txnCnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
